mac_accum_4bit: RTL
===================

# mac_accum_4bit

Sequential multiply-accumulate stage that sits directly downstream of the 4-bit array multiplier. It accepts a stream of 4-bit operand pairs over a valid/ready handshake and registers each pair. It forms the 8-bit product with the combinational array multiplier and sums the products into an ACC_W-bit accumulator. When the beat flagged `in_last` has been accumulated, it presents the frame total and beat count on a held output handshake.

## Interface
- `ACC_W`, 16, accumulator/result width; legal range 8..32.
- `CNT_W`, 8, beat-counter width; legal range 1..16.

- `clk` input 1: single clock, rising edge.
- `rst_n` input 1: asynchronous active-low reset.
- `in_valid` input 1: operand beat valid.
- `in_ready` output 1: stage can accept a beat.
- `in_a` input 4: multiplicand, unsigned.
- `in_b` input 4: multiplier, unsigned.
- `in_last` input 1: beat closes the current frame.
- `out_valid` output 1: frame result valid.
- `out_ready` input 1: downstream accepts the result.
- `out_sum` output ACC_W: frame sum of products.
- `out_count` output CNT_W: beats in the frame.
- `out_ovf` output 1: sticky, accumulator carried out during the frame.

## Operation
- Transfer occurs on any rising edge where `in_valid && in_ready`; `in_a`, `in_b`, `in_last` are captured into a pipe register with flag `p_vld`.
- The product is `p_a * p_b`, computed combinationally from the pipe register by an instance of the array multiplier. It is 8 bits, zero-extended to ACC_W+1 for the add.
- FSM states:
  - ACCUM (reset state): `in_ready = !(p_vld && p_last)`.
  - HOLD: `in_ready = 0`, `out_valid = 1`.
- On each edge with `p_vld`:
  - `acc <= acc + product`.
  - `cnt <= cnt + 1`; wraps modulo 2^CNT_W.
  - `ovf <= ovf | carry`.
- If `p_last` is also set on that edge:
  - Load `out_sum`, `out_count`, `out_ovf` with the post-update values.
  - Clear `acc`, `cnt`, `ovf` to 0.
  - Go to HOLD.
- HOLD → ACCUM on the edge where `out_valid && out_ready`. Outputs hold stable while `out_ready` is low.
- `in_valid` while `in_ready = 0` is ignored; there is no capture and no side effect.
- A zero-length frame is impossible. Every frame contains at least the beat that carries `in_last`.
- Reset values:
  - `in_ready = 1`, `out_valid = 0`.
  - `out_sum = 0`, `out_count = 0`, `out_ovf = 0`.
  - `acc`, `cnt`, `p_vld`: 0.
  - State: ACCUM.
- Reset asserted mid-frame or in HOLD discards all partial and held results immediately. This is asynchronous and does not wait for a clock edge.

## Timing
- Throughput: one beat per cycle within a frame.
- Latency: last beat accepted at edge k; `out_valid` rises after edge k+1.
- `in_ready` is low from after edge k until the edge where the result is consumed.
  - The cycle after that consumption edge, `in_ready = 1`.
  - Minimum frame-to-frame gap: 2 idle input cycles with `out_ready` tied high.
- The `in_ready` output depends only on registered state and is registered-derived. It has no combinational path from `in_valid` or `out_ready`.
- `out_*` are driven straight from registers.

## Configuration
- `MAC_ACCUM_SATURATE_EN` defined:
  - On carry-out, `acc` is forced to 2^ACC_W−1 and stays there for the rest of the frame.
  - `out_ovf` is set as normal.
- Not defined:
  - `acc` wraps modulo 2^ACC_W.
  - `out_ovf` is set as normal.
  - `out_sum` is the wrapped value.

## Test plan
- Frame (3,5),(15,15),(2,7,last), `out_ready = 1`, ACC_W=16 → `out_sum = 254`, `out_count = 3`, `out_ovf = 0`. `out_valid` is high exactly one cycle after the last beat is accepted.
- Single-beat frame (15,15,last) with `out_ready` low for 5 cycles → `out_sum = 225`, `out_count = 1` held stable. `in_ready = 0` throughout; `in_valid` pulses are ignored. After `out_ready = 1`, the next frame starts from 0.
- ACC_W=8, frame (15,15),(15,15,last) → without macro: `out_sum = 194`, `out_ovf = 1`. With `MAC_ACCUM_SATURATE_EN`: `out_sum = 255`, `out_ovf = 1`. The following frame (1,1,last) gives `out_sum = 1`, `out_ovf = 0`.
- `rst_n` low for 1 cycle after 2 beats of a frame → all outputs return to reset values at once. The next frame (4,4,last) gives `out_sum = 16`, `out_count = 1`.
- CNT_W=2, frame of 5 beats of (1,1) with last on the 5th → `out_sum = 5`, `out_count = 1` (wrapped).
- Back-to-back frames with continuous `in_valid` and `out_ready = 1` → no beat lost or duplicated. The sum of all `out_sum` values equals the reference total of products.

Source files
------------

// File: rtl/mac_accum_4bit.sv
// mac_accum_4bit: multiply-accumulate stage behind a 4x4 array multiplier.
// Each operand beat is registered. Its 8-bit product is added into an ACC_W-bit
// accumulator. The beat flagged last closes the frame. That frame's sum, its
// beat count and a sticky carry flag are then held on the output handshake
// until the result is consumed.
//
// Build option: MAC_ACCUM_SATURATE_EN
//   defined   - accumulator clamps at all-ones after a carry, for the rest of the frame
//   undefined - accumulator wraps modulo 2^ACC_W
//
// Ports:
//   clk, rst_n          clock (rising edge), asynchronous active-low reset
//   in_valid/in_ready   operand beat handshake
//   in_a, in_b          4-bit unsigned operands
//   in_last             beat closes the current frame
//   out_valid/out_ready result handshake (result held while out_ready is low)
//   out_sum             frame sum of products (ACC_W bits)
//   out_count           beats in the frame (CNT_W bits, wraps)
//   out_ovf             accumulator carried out during the frame

// Combinational 4x4 unsigned array multiplier, built as shifted partial-product rows.
module mac_accum_4bit_mul (
  input  logic [3:0] a,
  input  logic [3:0] b,
  output logic [7:0] p
);
  always_comb begin
    p = '0;
    for (int i = 0; i < 4; i++) begin
      if (b[i]) p = p + ({4'b0000, a} << i);
    end
  end
endmodule

// FSM states
//   state | meaning
//   ACCUM | accepting beats, summing products into acc
//   HOLD  | frame result presented, waiting for out_ready
module mac_accum_4bit #(
  parameter int ACC_W = 16,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       in_a,
  input  logic [3:0]       in_b,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_sum,
  output logic [CNT_W-1:0] out_count,
  output logic             out_ovf
);

  typedef enum logic {ACCUM = 1'b0, HOLD = 1'b1} state_t;

  state_t state_q, state_d;

  logic             p_vld, p_last;
  logic [3:0]       p_a, p_b;
  logic [7:0]       prod;

  logic [ACC_W-1:0] acc, acc_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             ovf, ovf_nxt;
  logic [ACC_W:0]   sum_ext;
  logic             accept;

  mac_accum_4bit_mul u_mul (
    .a (p_a),
    .b (p_b),
    .p (prod)
  );

  assign accept  = in_valid && in_ready;
  assign sum_ext = {1'b0, acc} + {{(ACC_W-7){1'b0}}, prod};
  assign ovf_nxt = ovf | sum_ext[ACC_W];
  assign cnt_nxt = cnt + CNT_W'(1);

`ifdef MAC_ACCUM_SATURATE_EN
  // ovf is sticky for the frame, so once set the accumulator stays clamped.
  assign acc_nxt = ovf_nxt ? {ACC_W{1'b1}} : sum_ext[ACC_W-1:0];
`else
  assign acc_nxt = sum_ext[ACC_W-1:0];
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ACCUM;
    else        state_q <= state_d;
  end

  // in_ready decodes only registered state: it drops as soon as the last beat
  // sits in the pipe, so nothing enters while that frame is being closed.
  always_comb begin
    state_d   = state_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state_q)
      ACCUM: begin
        in_ready = !(p_vld && p_last);
        if (p_vld && p_last) state_d = HOLD;
      end
      HOLD: begin
        out_valid = 1'b1;
        if (out_ready) state_d = ACCUM;
      end
      default: state_d = ACCUM;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      p_vld     <= 1'b0;
      p_last    <= 1'b0;
      p_a       <= '0;
      p_b       <= '0;
      acc       <= '0;
      cnt       <= '0;
      ovf       <= 1'b0;
      out_sum   <= '0;
      out_count <= '0;
      out_ovf   <= 1'b0;
    end else begin
      p_vld <= accept;
      if (accept) begin
        p_a    <= in_a;
        p_b    <= in_b;
        p_last <= in_last;
      end
      if (p_vld) begin
        if (p_last) begin
          out_sum   <= acc_nxt;
          out_count <= cnt_nxt;
          out_ovf   <= ovf_nxt;
          acc       <= '0;
          cnt       <= '0;
          ovf       <= 1'b0;
        end else begin
          acc <= acc_nxt;
          cnt <= cnt_nxt;
          ovf <= ovf_nxt;
        end
      end
    end
  end

endmodule
